// File: rtl/pwm_pkg.sv
// Purpose: shared defaults, width helper and parameter sanity check for the PWM generator family.
// Latency: n/a (constants and constant functions only).
// Backpressure: n/a.
package pwm_pkg;

    localparam int PWM_NUM_CH_DEF    = 4;
    localparam int PWM_CNT_W_DEF     = 8;
    localparam int PWM_PERIOD_DEF    = 100;
    localparam int PWM_STEP_DEF      = 10;
    localparam int PWM_DUTY_MIN_DEF  = 10;
    localparam int PWM_DUTY_MAX_DEF  = 90;
    localparam int PWM_DUTY_INIT_DEF = 50;
    localparam int PWM_DEB_DIV_DEF   = 25000000;

    // Bits needed to index n items, never less than one so a 1-channel build keeps a legal port.
    function automatic int clog2_min1(input int n);
        int w;
        w = 0;
        for (int k = 0; k < 31; k++) begin
            if ((1 << k) < n) w = k + 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

    // Duty values are stored in CNT_W bits, so DUTY_MAX must also fit below 2**CNT_W.
    function automatic bit pwm_params_ok(input int num_ch, input int cnt_w, input int period,
                                         input int step, input int dmin, input int dmax,
                                         input int dinit, input int deb_div);
        bit ok;
        ok = (num_ch >= 1) && (cnt_w >= 1) && (cnt_w <= 30) && (period >= 2) &&
             (period <= (1 << cnt_w)) && (step >= 0) && (step < (1 << cnt_w)) &&
             (dmin >= 0) && (dmin <= dinit) && (dinit <= dmax) && (dmax <= period) &&
             (dmax < (1 << cnt_w)) && (deb_div >= 2);
        return ok;
    endfunction

endpackage

// File: rtl/pwm_btn_debounce.sv
// Purpose: samples one raw button on the shared debounce tick and emits a single pulse per rising edge.
// Latency: press asserts on the second tick after the button is first seen high.
// Backpressure: none; a held button produces exactly one press.
module pwm_btn_debounce (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic btn,
    output logic press
);

    logic s1;
    logic s2;

    // Two-deep history advanced only on the slow tick, which filters contact bounce.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else if (tick) begin
            s1 <= btn;
            s2 <= s1;
        end
    end

    assign press = s1 & ~s2 & tick;

endmodule

// File: rtl/pwm_multichannel_gen.sv
// Purpose: NUM_CH PWM outputs from one period counter, per-channel button-adjusted duty, optional stagger.
// Latency: 1 cycle from counter value to pwm_out/period_start; duty changes take effect at the next period.
// Backpressure: none; outputs free-run, duty_rd is a combinational view of the pending duty.
module pwm_multichannel_gen
    import pwm_pkg::*;
#(
    parameter int NUM_CH    = PWM_NUM_CH_DEF,
    parameter int CNT_W     = PWM_CNT_W_DEF,
    parameter int PERIOD    = PWM_PERIOD_DEF,
    parameter int STEP      = PWM_STEP_DEF,
    parameter int DUTY_MIN  = PWM_DUTY_MIN_DEF,
    parameter int DUTY_MAX  = PWM_DUTY_MAX_DEF,
    parameter int DUTY_INIT = PWM_DUTY_INIT_DEF,
    parameter int DEB_DIV   = PWM_DEB_DIV_DEF,
    localparam int CH_W     = clog2_min1(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              stagger_mode,
    input  logic [CH_W-1:0]   ch_sel,
    input  logic              increase_duty,
    input  logic              decrease_duty,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              period_start,
    output logic [CNT_W-1:0]  duty_rd
);

    localparam int CW1   = CNT_W + 1;
    localparam int DEB_W = clog2_min1(DEB_DIV);
    localparam int PH_OFS = PERIOD / NUM_CH;

    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] INIT_V   = CNT_W'(DUTY_INIT);
    localparam logic [CNT_W-1:0] MIN_V    = CNT_W'(DUTY_MIN);
    localparam logic [CNT_W-1:0] MAX_V    = CNT_W'(DUTY_MAX);
    localparam logic [CW1-1:0]   MIN_W    = CW1'(DUTY_MIN);
    localparam logic [CW1-1:0]   MAX_W    = CW1'(DUTY_MAX);
    localparam logic [CW1-1:0]   STEP_W   = CW1'(STEP);
    localparam logic [CW1-1:0]   PERIOD_W = CW1'(PERIOD);

    if (!pwm_params_ok(NUM_CH, CNT_W, PERIOD, STEP, DUTY_MIN, DUTY_MAX, DUTY_INIT, DEB_DIV)) begin : g_param_err
        $error("pwm_multichannel_gen: illegal parameter combination");
    end

    logic [DEB_W-1:0] deb_cnt;
    logic             tick;
    logic             inc_press;
    logic             dec_press;
    logic [CNT_W-1:0] duty_pend [NUM_CH];
    logic [CNT_W-1:0] duty_act  [NUM_CH];
    logic             mode_act;
    logic [CNT_W-1:0] cnt;
    logic             at_last;
    logic             load;
    logic             sel_ok;
    logic [CNT_W-1:0] sel_duty;
    logic [CNT_W-1:0] duty_nxt;
    logic             duty_upd;
    logic [CNT_W-1:0] phase [NUM_CH];

    assign tick = (deb_cnt == DEB_LAST);

    // Free-running debounce sample divider, independent of enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) deb_cnt <= '0;
        else        deb_cnt <= tick ? '0 : deb_cnt + 1'b1;
    end

    pwm_btn_debounce u_inc (.clk(clk), .rst_n(rst_n), .tick(tick), .btn(increase_duty), .press(inc_press));
    pwm_btn_debounce u_dec (.clk(clk), .rst_n(rst_n), .tick(tick), .btn(decrease_duty), .press(dec_press));

    // Channel select mux; an out-of-range ch_sel matches nothing, reads 0 and blocks updates.
    always_comb begin
        sel_ok   = 1'b0;
        sel_duty = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_sel == CH_W'(i)) begin
                sel_ok   = 1'b1;
                sel_duty = duty_pend[i];
            end
        end
    end

    assign duty_rd  = sel_duty;
    assign duty_upd = sel_ok & (inc_press ^ dec_press);

    // Saturating step computed one bit wider so neither direction can wrap.
    always_comb begin
        logic [CW1-1:0] inc_sum;
        logic [CW1-1:0] dec_dif;
        inc_sum = {1'b0, sel_duty} + STEP_W;
        dec_dif = {1'b0, sel_duty} - STEP_W;
        if (inc_press) begin
            duty_nxt = (inc_sum > MAX_W) ? MAX_V : inc_sum[CNT_W-1:0];
        end else begin
            duty_nxt = (({1'b0, sel_duty} >= STEP_W) && (dec_dif >= MIN_W)) ? dec_dif[CNT_W-1:0] : MIN_V;
        end
    end

    // Pending duty registers written by accepted presses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) duty_pend[i] <= INIT_V;
        end else if (duty_upd) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_sel == CH_W'(i)) duty_pend[i] <= duty_nxt;
            end
        end
    end

    assign at_last = (cnt == CNT_LAST);
    assign load    = ~enable | at_last;

    // Shared period counter, parked at 0 while disabled so re-enable starts a fresh period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       cnt <= '0;
        else if (!enable) cnt <= '0;
        else if (at_last) cnt <= '0;
        else              cnt <= cnt + 1'b1;
    end

    // Shadow load at the period boundary (every cycle while disabled) keeps edges glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) duty_act[i] <= INIT_V;
            mode_act <= 1'b0;
        end else if (load) begin
            duty_act <= duty_pend;
            mode_act <= stagger_mode;
        end
    end

    // Per-channel phase: counter plus an even share of the period when staggered, folded mod PERIOD.
    always_comb begin
        logic [CW1-1:0] sum;
        sum = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sum      = {1'b0, cnt} + (mode_act ? CW1'(i * PH_OFS) : CW1'(0));
            phase[i] = (sum >= PERIOD_W) ? CNT_W'(sum - PERIOD_W) : sum[CNT_W-1:0];
        end
    end

    // Registered compare outputs and period marker.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_out      <= '0;
            period_start <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) pwm_out[i] <= enable & (phase[i] < duty_act[i]);
            period_start <= enable & (cnt == '0);
        end
    end

endmodule

// File: tb/tb_pwm_multichannel_gen.sv
module tb_pwm_multichannel_gen;

    localparam int NCH   = 3;
    localparam int CW    = 8;
    localparam int PER   = 10;
    localparam int STP   = 1;
    localparam int DMIN  = 1;
    localparam int DMAX  = 9;
    localparam int DINIT = 5;
    localparam int DDIV  = 4;
    localparam int SW    = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           enable = 1'b0;
    logic           stagger_mode = 1'b0;
    logic [SW-1:0]  ch_sel = '0;
    logic           increase_duty = 1'b0;
    logic           decrease_duty = 1'b0;
    logic [NCH-1:0] pwm_out;
    logic           period_start;
    logic [CW-1:0]  duty_rd;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pwm_multichannel_gen #(
        .NUM_CH(NCH), .CNT_W(CW), .PERIOD(PER), .STEP(STP),
        .DUTY_MIN(DMIN), .DUTY_MAX(DMAX), .DUTY_INIT(DINIT), .DEB_DIV(DDIV)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .stagger_mode(stagger_mode),
        .ch_sel(ch_sel), .increase_duty(increase_duty), .decrease_duty(decrease_duty),
        .pwm_out(pwm_out), .period_start(period_start), .duty_rd(duty_rd)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [NCH-1:0] pwm;
        logic           ps;
        int             rd;
    } exp_t;

    exp_t sbq[$];

    // Reference model: requested duty per channel, duty in force, position within the period,
    // number of clocks since reset (tick every DDIV-th), and the last two tick samples of each button.
    int m_pend [NCH];
    int m_act  [NCH];
    bit m_mode;
    int m_pos;
    int m_clocks;
    bit inc_seen [2];
    bit dec_seen [2];

    function automatic void model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_pend[i] = DINIT;
            m_act[i]  = DINIT;
        end
        m_mode   = 1'b0;
        m_pos    = 0;
        m_clocks = 0;
        inc_seen[0] = 1'b0; inc_seen[1] = 1'b0;
        dec_seen[0] = 1'b0; dec_seen[1] = 1'b0;
    endfunction

    always @(posedge clk) begin
        exp_t e;
        bit   is_tick;
        bit   ip;
        bit   dp;
        int   ph;
        e.pwm = '0;
        e.ps  = 1'b0;
        e.rd  = 0;
        if (!rst_n) begin
            model_reset();
        end else begin
            is_tick = (m_clocks % DDIV) == DDIV - 1;
            m_clocks++;
            for (int i = 0; i < NCH; i++) begin
                ph = (m_pos + (m_mode ? i * (PER / NCH) : 0)) % PER;
                e.pwm[i] = enable && (ph < m_act[i]);
            end
            e.ps = enable && (m_pos == 0);
            if (!enable || m_pos == PER - 1) begin
                m_act  = m_pend;
                m_mode = stagger_mode;
            end
            if (is_tick) begin
                ip = inc_seen[0] && !inc_seen[1];
                dp = dec_seen[0] && !dec_seen[1];
                inc_seen[1] = inc_seen[0]; inc_seen[0] = increase_duty;
                dec_seen[1] = dec_seen[0]; dec_seen[0] = decrease_duty;
                if (ip != dp && int'(ch_sel) < NCH) begin
                    if (ip) m_pend[ch_sel] = (m_pend[ch_sel] + STP > DMAX) ? DMAX : m_pend[ch_sel] + STP;
                    else    m_pend[ch_sel] = (m_pend[ch_sel] - STP < DMIN) ? DMIN : m_pend[ch_sel] - STP;
                end
            end
            m_pos = enable ? (m_pos + 1) % PER : 0;
        end
        #1;
        e.rd = (int'(ch_sel) < NCH) ? m_pend[ch_sel] : 0;
        sbq.push_back(e);
    end

    // Monitor: every clock the DUT presents a fresh output set; compare against the oldest expectation.
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            chk("pwm_out", 32'(pwm_out), 32'(e.pwm));
            chk("period_start", 32'(period_start), 32'(e.ps));
            chk("duty_rd", 32'(duty_rd), e.rd);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One clean press: held across two ticks, then released across two ticks.
    task automatic tap(input bit inc, input bit dec);
        increase_duty = inc;
        decrease_duty = dec;
        cyc(2 * DDIV);
        increase_duty = 1'b0;
        decrease_duty = 1'b0;
        cyc(2 * DDIV);
    endtask

    initial begin
        #200000;
        n_bad++;
        $display("FAIL watchdog: run did not finish, time %0t", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        cyc(3);
        chk("reset_pwm", 32'(pwm_out), 0);
        chk("reset_ps", 32'(period_start), 0);
        chk("reset_duty_rd", 32'(duty_rd), DINIT);

        rst_n  = 1'b1;
        enable = 1'b1;
        cyc(30);

        ch_sel = 2'd1;
        tap(1'b1, 1'b0);
        chk("inc_ch1", 32'(duty_rd), 6);
        cyc(20);

        ch_sel = 2'd0;
        increase_duty = 1'b1;
        cyc(40 * DDIV);
        increase_duty = 1'b0;
        cyc(2 * DDIV);
        chk("held_once", 32'(duty_rd), 6);
        repeat (8) tap(1'b1, 1'b0);
        chk("sat_max", 32'(duty_rd), DMAX);
        repeat (10) tap(1'b0, 1'b1);
        chk("sat_min", 32'(duty_rd), DMIN);
        repeat (4) tap(1'b1, 1'b0);
        chk("restore_ch0", 32'(duty_rd), 5);
        ch_sel = 2'd1;
        tap(1'b0, 1'b1);
        chk("restore_ch1", 32'(duty_rd), 5);

        stagger_mode = 1'b1;
        cyc(33);

        enable = 1'b0;
        @(posedge clk);
        #1;
        chk("disable_pwm", 32'(pwm_out), 0);
        chk("disable_ps", 32'(period_start), 0);
        @(negedge clk);
        ch_sel = 2'd0;
        tap(1'b1, 1'b0);
        chk("press_disabled", 32'(duty_rd), 6);
        enable = 1'b1;
        cyc(25);

        tap(1'b1, 1'b1);
        chk("inc_dec_same_tick", 32'(duty_rd), 6);

        ch_sel = 2'd3;
        #1;
        chk("oor_read", 32'(duty_rd), 0);
        @(negedge clk);
        tap(1'b1, 1'b0);
        chk("oor_press", 32'(duty_rd), 0);
        ch_sel = 2'd2;
        #1;
        chk("ch2_untouched", 32'(duty_rd), 5);
        @(negedge clk);
        tap(1'b1, 1'b0);
        chk("ch2_inc", 32'(duty_rd), 6);

        cyc(4);
        rst_n = 1'b0;
        #1;
        chk("arst_pwm", 32'(pwm_out), 0);
        chk("arst_ps", 32'(period_start), 0);
        chk("arst_duty", 32'(duty_rd), DINIT);
        cyc(2);
        rst_n = 1'b1;
        cyc(20);

        for (int k = 0; k < 300; k++) begin
            increase_duty = ($urandom_range(0, 3) == 0);
            decrease_duty = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) ch_sel = SW'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) stagger_mode = ~stagger_mode;
            enable = ($urandom_range(0, 19) != 0);
            cyc($urandom_range(1, 6));
        end
        cyc(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
